// File: rtl/score_bcd_ctrl.sv
// Sequential binary-to-BCD converter for the score display path.
// It shifts and adds 3 (double-dabble) on one bit per clock and holds four registered digits.
module score_bcd_ctrl #(
   parameter int WIDTH   = 14,
   parameter int MAX_VAL = 9999
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic [3:0]       thou,
   output logic [3:0]       hund,
   output logic [3:0]       tens,
   output logic [3:0]       units,
   output logic             ovf
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MAX_VEC  = WIDTH'(MAX_VAL);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_n;
   logic             accept;
   logic             finish;
   logic             over;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_n;
   logic [15:0]      scratch;
   logic [15:0]      adj;
   logic [15:0]      scratch_n;
   logic [CNT_W-1:0] cnt;
   logic             ovf_pend;
   logic [15:0]      result;

   // A scratch digit of 5 or more would reach 10 or more after doubling, so it is corrected first.
   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      req_ready = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (cnt == LAST_CNT) begin
               finish  = 1'b1;
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      over      = (bin_in > MAX_VEC);
      adj       = {add3(scratch[15:12]), add3(scratch[11:8]),
                   add3(scratch[7:4]),   add3(scratch[3:0])};
      scratch_n = (adj << 1) | {15'd0, shift_reg[WIDTH-1]};
      shift_n   = shift_reg << 1;
   end

   // Results are copied out only on the finishing edge, so the display never sees partial scratch.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         scratch   <= '0;
         cnt       <= '0;
         ovf_pend  <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= finish;
         if (accept) begin
            shift_reg <= over ? MAX_VEC : bin_in;
            ovf_pend  <= over;
            scratch   <= '0;
            cnt       <= '0;
         end else if (state == S_SHIFT) begin
            shift_reg <= shift_n;
            scratch   <= scratch_n;
            cnt       <= cnt + CNT_W'(1);
            if (finish) begin
               result <= scratch_n;
               ovf    <= ovf_pend;
            end
         end
      end
   end

   assign thou  = result[15:12];
   assign hund  = result[11:8];
   assign tens  = result[7:4];
   assign units = result[3:0];

endmodule

// File: tb/tb_score_bcd_ctrl.sv
// Directed bench for score_bcd_ctrl: handshake, latency, saturation, reset abort and a strided sweep.
module tb_score_bcd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [13:0] bin_in;
   logic        busy;
   logic        done;
   logic [3:0]  thou;
   logic [3:0]  hund;
   logic [3:0]  tens;
   logic [3:0]  units;
   logic        ovf;
   logic [15:0] digits;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_done_cyc = 0;
   int prev_cyc;
   int done_seen;
   logic [15:0] prev_bcd;
   logic        prev_ovf;

   score_bcd_ctrl #(.WIDTH(14), .MAX_VAL(9999)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .bin_in(bin_in), .busy(busy), .done(done), .thou(thou), .hund(hund),
      .tens(tens), .units(units), .ovf(ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign digits = {thou, hund, tens, units};

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] bcd_model(input int v);
      int m;
      m = (v > 9999) ? 9999 : v;
      return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
   task automatic apply_stimulus(input logic [13:0] v, input logic [15:0] hold_bcd, input logic hold_ovf,
                                 input logic [15:0] exp_bcd, input logic exp_ovf);
      int lat;
      int busy_n;
      req_valid = 1'b1;
      bin_in    = v;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      bin_in    = 14'h2aaa;
      lat       = -1;
      busy_n    = 0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         if (busy) busy_n++;
         if (i == 7) begin
            check_output("hold_digits", 32'(digits), 32'(hold_bcd));
            check_output("hold_ovf", 32'(ovf), 32'(hold_ovf));
         end
         if (done) begin
            lat = i;
            break;
         end
      end
      last_done_cyc = cyc;
      check_output("latency", 32'(lat), 32'd14);
      check_output("busy_cycles", 32'(busy_n), 32'd15);
      check_output("digits", 32'(digits), 32'(exp_bcd));
      check_output("ovf", 32'(ovf), 32'(exp_ovf));
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      bin_in    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("rst_ready", 32'(req_ready), 32'd1);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_digits", 32'(digits), 32'h0);
      check_output("rst_ovf", 32'(ovf), 32'd0);

      req_valid = 1'b1;
      bin_in    = 14'd1234;
      @(negedge clk);
      check_output("rst_wins_busy", 32'(busy), 32'd0);
      check_output("rst_wins_ready", 32'(req_ready), 32'd1);
      rst       = 1'b0;
      req_valid = 1'b0;

      $display("[TB] basic conversion 1234");
      apply_stimulus(14'd1234, 16'h0000, 1'b0, 16'h1234, 1'b0);
      @(negedge clk);
      check_output("e15_done", 32'(done), 32'd0);
      check_output("e15_ready", 32'(req_ready), 32'd1);
      check_output("e15_busy", 32'(busy), 32'd0);

      $display("[TB] saturation and boundaries");
      apply_stimulus(14'd16383, 16'h1234, 1'b0, 16'h9999, 1'b1);
      @(negedge clk);
      apply_stimulus(14'd0, 16'h9999, 1'b1, 16'h0000, 1'b0);
      @(negedge clk);
      apply_stimulus(14'd9999, 16'h0000, 1'b0, 16'h9999, 1'b0);
      @(negedge clk);
      apply_stimulus(14'd10000, 16'h9999, 1'b0, 16'h9999, 1'b1);

      $display("[TB] valid held high with changing data");
      @(negedge clk);
      req_valid = 1'b1;
      bin_in    = 14'd42;
      @(posedge clk);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i == 14) begin
            check_output("held_done", 32'(done), 32'd1);
            check_output("held_digits", 32'(digits), 32'h0042);
            check_output("held_ovf", 32'(ovf), 32'd0);
         end
         bin_in = 14'(100 * i + 1);
      end
      @(negedge clk);
      check_output("held_e15_ready", 32'(req_ready), 32'd1);
      check_output("held_e15_busy", 32'(busy), 32'd0);
      bin_in = 14'd777;
      @(posedge clk);
      @(negedge clk);
      check_output("held_e16_busy", 32'(busy), 32'd1);
      check_output("held_e16_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      bin_in    = '0;
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         @(negedge clk);
      end
      check_output("second_done", 32'(done), 32'd1);
      check_output("second_digits", 32'(digits), 32'h0777);

      $display("[TB] reset during conversion");
      @(negedge clk);
      req_valid = 1'b1;
      bin_in    = 14'd5678;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_ready", 32'(req_ready), 32'd1);
      check_output("abort_digits", 32'(digits), 32'h0);
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check_output("abort_no_done", 32'(done_seen), 32'd0);
      check_output("abort_digits_after", 32'(digits), 32'h0);

      $display("[TB] strided back-to-back sweep");
      prev_bcd = 16'h0000;
      prev_ovf = 1'b0;
      prev_cyc = 0;
      for (int v = 0; v <= 9999; v += 37) begin
         apply_stimulus(14'(v), prev_bcd, prev_ovf, bcd_model(v), 1'b0);
         if (v > 0) check_output("done_spacing", 32'(last_done_cyc - prev_cyc), 32'd16);
         prev_cyc = last_done_cyc;
         prev_bcd = bcd_model(v);
         @(negedge clk);
      end
      apply_stimulus(14'd9999, prev_bcd, prev_ovf, 16'h9999, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
